// File: rtl/clk_pkg.sv
// Shared constants for the clock-buffer lanes behind the clock wizard outputs.
package clk_pkg;

    localparam int SEQ_DEPTH_DEFAULT = 8;
    localparam int CNT_W_DEFAULT     = 16;
    localparam int SEQ_DEPTH_MIN     = 2;
    localparam int SEQ_DEPTH_MAX     = 32;

endpackage

// File: rtl/clk_buf_gate_if.sv
// Control and observation bundle of one clock-buffer lane (clock and reset stay plain ports).
interface clk_buf_gate_if #(
    parameter int SEQ_DEPTH = 8,
    parameter int CNT_W     = 16
);

    logic                 locked;
    logic                 ce;
    logic                 clk_bufg;
    logic                 clk_bufh;
    logic                 clk_gated;
    logic                 gate_en;
    logic [SEQ_DEPTH-1:0] seq_state;
    logic [CNT_W-1:0]     gated_cnt;

    modport master (
        output locked, ce,
        input  clk_bufg, clk_bufh, clk_gated, gate_en, seq_state, gated_cnt
    );

    modport slave (
        input  locked, ce,
        output clk_bufg, clk_bufh, clk_gated, gate_en, seq_state, gated_cnt
    );

endinterface

// File: rtl/clk_gate_cell.sv
// BUFGCE behaviour: enable captured while the clock is low, then ANDed with the clock,
// so the gated output only ever carries whole source high phases.
module clk_gate_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic en_lat,
    output logic gclk
);

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_lat <= 1'b0;
        end else begin
            en_lat <= en;
        end
    end

    assign gclk = clk & en_lat;

endmodule

// File: rtl/clk_buf_gate.sv
// One clock-buffer lane: BUFG/BUFH copies, lock-qualified enable sequencer and a BUFGCE
// gate with a count of the pulses it lets through.
module clk_buf_gate
    import clk_pkg::*;
#(
    parameter int SEQ_DEPTH = SEQ_DEPTH_DEFAULT,
    parameter int CNT_W     = CNT_W_DEFAULT
) (
    input  logic          clk_in1,
    input  logic          rst_n,
    clk_buf_gate_if.slave bus
);

    if (SEQ_DEPTH < SEQ_DEPTH_MIN || SEQ_DEPTH > SEQ_DEPTH_MAX) begin : g_bad_depth
        $error("clk_buf_gate: SEQ_DEPTH out of range");
    end

    logic                 clk_bufh;
    logic [SEQ_DEPTH-1:0] seq;
    logic                 gate_en;
    logic                 en_lat;
    logic                 clk_gated;
    logic [CNT_W-1:0]     cnt;

    assign clk_bufh     = clk_in1;
    assign bus.clk_bufg = clk_in1;
    assign bus.clk_bufh = clk_bufh;

    // Lock must survive SEQ_DEPTH consecutive samples; loss of lock drains out the same way.
    always_ff @(posedge clk_bufh or negedge rst_n) begin
        if (!rst_n) begin
            seq <= '0;
        end else begin
            seq <= {seq[SEQ_DEPTH-2:0], bus.locked};
        end
    end

    assign gate_en = seq[SEQ_DEPTH-1];

    clk_gate_cell u_gate (
        .clk    (clk_in1),
        .rst_n  (rst_n),
        .en     (gate_en & bus.ce),
        .en_lat (en_lat),
        .gclk   (clk_gated)
    );

    // en_lat is stable across the high phase, so this edge is exactly a clk_gated rise.
    always_ff @(posedge clk_in1 or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en_lat) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign bus.clk_gated = clk_gated;
    assign bus.gate_en   = gate_en;
    assign bus.seq_state = seq;
    assign bus.gated_cnt = cnt;

endmodule

// File: tb/tb_clk_buf_gate.sv
// Directed bench for clk_buf_gate: depth-8 lane with a 16-bit counter, and a depth-2 lane
// with a 4-bit counter for the short-sequencer and wrap cases.
`timescale 1ns/1ps
module tb_clk_buf_gate;

    logic clk;
    logic rst_n;
    logic rst2_n;

    clk_buf_gate_if #(.SEQ_DEPTH(8), .CNT_W(16)) bus8 ();
    clk_buf_gate_if #(.SEQ_DEPTH(2), .CNT_W(4))  bus2 ();

    clk_buf_gate #(.SEQ_DEPTH(8), .CNT_W(16)) dut8 (
        .clk_in1 (clk),
        .rst_n   (rst_n),
        .bus     (bus8)
    );

    clk_buf_gate #(.SEQ_DEPTH(2), .CNT_W(4)) dut2 (
        .clk_in1 (clk),
        .rst_n   (rst2_n),
        .bus     (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Runt detector on the depth-8 lane: every clk_gated pulse rises with the source
    // clock and lasts a full half period unless reset cut it short.
    realtime t_rise = 0.0;
    always @(posedge bus8.clk_gated) begin
        t_rise = $realtime;
        chk("gated_rise_with_clk", {31'd0, clk}, 32'd1);
    end
    always @(negedge bus8.clk_gated) begin
        if (rst_n) begin
            chk("gated_pulse_full", {31'd0, ($realtime - t_rise) > 4.9}, 32'd1);
        end
    end

    typedef struct {
        logic        lk;
        logic        ce;
        logic [7:0]  seq;
        logic        ge;
        logic        gh;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl [25];

    task automatic check8(input string tag, input logic [7:0] seq, input logic ge,
                          input logic gh, input logic [15:0] cnt);
        chk({tag, "_seq"},   {24'd0, bus8.seq_state}, {24'd0, seq});
        chk({tag, "_ge"},    {31'd0, bus8.gate_en},   {31'd0, ge});
        chk({tag, "_gated"}, {31'd0, bus8.clk_gated}, {31'd0, gh});
        chk({tag, "_cnt"},   {16'd0, bus8.gated_cnt}, {16'd0, cnt});
        chk({tag, "_bufg"},  {31'd0, bus8.clk_bufg},  {31'd0, clk});
        chk({tag, "_bufh"},  {31'd0, bus8.clk_bufh},  {31'd0, clk});
    endtask

    initial begin
        #100us;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        rst2_n      = 1'b0;
        bus8.locked = 1'b1;
        bus8.ce     = 1'b1;
        bus2.locked = 1'b1;
        bus2.ce     = 1'b1;

        // Release sequence, ce gap, then loss of lock: one row per rising edge.
        tbl[0]  = '{1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 16'd0};
        tbl[1]  = '{1'b1, 1'b1, 8'h03, 1'b0, 1'b0, 16'd0};
        tbl[2]  = '{1'b1, 1'b1, 8'h07, 1'b0, 1'b0, 16'd0};
        tbl[3]  = '{1'b1, 1'b1, 8'h0F, 1'b0, 1'b0, 16'd0};
        tbl[4]  = '{1'b1, 1'b1, 8'h1F, 1'b0, 1'b0, 16'd0};
        tbl[5]  = '{1'b1, 1'b1, 8'h3F, 1'b0, 1'b0, 16'd0};
        tbl[6]  = '{1'b1, 1'b1, 8'h7F, 1'b0, 1'b0, 16'd0};
        tbl[7]  = '{1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 16'd0};
        tbl[8]  = '{1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 16'd1};
        tbl[9]  = '{1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 16'd2};
        tbl[10] = '{1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 16'd2};
        tbl[11] = '{1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 16'd2};
        tbl[12] = '{1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 16'd2};
        tbl[13] = '{1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 16'd3};
        tbl[14] = '{1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 16'd4};
        tbl[15] = '{1'b0, 1'b1, 8'hFE, 1'b1, 1'b1, 16'd5};
        tbl[16] = '{1'b0, 1'b1, 8'hFC, 1'b1, 1'b1, 16'd6};
        tbl[17] = '{1'b0, 1'b1, 8'hF8, 1'b1, 1'b1, 16'd7};
        tbl[18] = '{1'b0, 1'b1, 8'hF0, 1'b1, 1'b1, 16'd8};
        tbl[19] = '{1'b0, 1'b1, 8'hE0, 1'b1, 1'b1, 16'd9};
        tbl[20] = '{1'b0, 1'b1, 8'hC0, 1'b1, 1'b1, 16'd10};
        tbl[21] = '{1'b0, 1'b1, 8'h80, 1'b1, 1'b1, 16'd11};
        tbl[22] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 16'd12};
        tbl[23] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 16'd12};
        tbl[24] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 16'd12};

        // Held in reset with lock present and locked2 toggling.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            bus2.locked = ~bus2.locked;
            check8("reset", 8'h00, 1'b0, 1'b0, 16'd0);
            chk("reset2_seq", {30'd0, bus2.seq_state}, 32'd0);
            chk("reset2_cnt", {28'd0, bus2.gated_cnt}, 32'd0);
        end
        @(negedge clk);
        #1;
        chk("reset_low_bufg", {31'd0, bus8.clk_bufg}, {31'd0, clk});
        chk("reset_low_gated", {31'd0, bus8.clk_gated}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 25; i++) begin
            bus8.locked = tbl[i].lk;
            bus8.ce     = tbl[i].ce;
            @(posedge clk);
            #1;
            check8($sformatf("vec%0d", i), tbl[i].seq, tbl[i].ge, tbl[i].gh, tbl[i].cnt);
        end
        @(negedge clk);
        #1;
        chk("unlocked_low_gated", {31'd0, bus8.clk_gated}, 32'd0);

        // Relock, then reset asserted in the middle of a gated high phase.
        bus8.locked = 1'b1;
        repeat (9) @(posedge clk);
        #1;
        check8("relock", 8'hFF, 1'b1, 1'b1, 16'd13);
        #1;
        rst_n = 1'b0;
        #0.1;
        check8("midreset", 8'h00, 1'b0, 1'b0, 16'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk);
            #1;
            check8($sformatf("relock%0d", i),
                   (i >= 8) ? 8'hFF : 8'((1 << i) - 1),
                   i >= 8, i >= 9, (i >= 9) ? 16'd1 : 16'd0);
        end

        // Depth-2 lane: enable after 2 edges, 17 pulses wrap a 4-bit counter to 1.
        bus2.locked = 1'b1;
        @(posedge clk);
        #1;
        rst2_n = 1'b1;
        for (int i = 1; i <= 19; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("d2_seq%0d", i), {30'd0, bus2.seq_state}, (i >= 2) ? 32'd3 : 32'd1);
            chk($sformatf("d2_ge%0d", i), {31'd0, bus2.gate_en}, {31'd0, i >= 2});
            chk($sformatf("d2_gated%0d", i), {31'd0, bus2.clk_gated}, {31'd0, i >= 3});
            chk($sformatf("d2_cnt%0d", i), {28'd0, bus2.gated_cnt},
                (i >= 3) ? 32'((i - 2) % 16) : 32'd0);
            chk($sformatf("d2_bufg%0d", i), {31'd0, bus2.clk_bufg}, {31'd0, clk});
        end
        chk("d2_wrap_final", {28'd0, bus2.gated_cnt}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
